// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V-lite pipeline: datapath width, reset PC,
// the canonical NOP encoding and the fetch-stage state type.
package riscv_pkg;

    localparam int          NBITS     = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter register with its next-PC mux: hold, advance by one word,
// or load a redirect target with the byte-offset bits cleared.
module pc_gen
    import riscv_pkg::*;
#(
    parameter int               nbits    = NBITS,
    parameter logic [nbits-1:0] RESET_PC = riscv_pkg::RESET_PC
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_inc,
    input  logic             pc_redirect,
    input  logic [nbits-1:0] target,
    output logic [nbits-1:0] pc,
    output logic [nbits-1:0] pc_plus4
);

    logic [nbits-1:0] pc_q;
    logic [nbits-1:0] pc_d;

    // Plain modulo-2^nbits addition: wrapping past the top of memory is legal.
    assign pc_plus4 = pc_q + nbits'(4);

    always_comb begin
        pc_d = pc_q;
        if (pc_redirect) begin
            pc_d = {target[nbits-1:2], 2'b00};
        end else if (pc_inc) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= {RESET_PC[nbits-1:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word read at a time, fills the IF/ID
// register, honours decode stalls and kills in-flight reads on a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int               nbits    = NBITS,
    parameter logic [nbits-1:0] RESET_PC = riscv_pkg::RESET_PC
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [nbits-1:0] BR_TARGET,
    output logic             IMEM_REQ,
    output logic [nbits-1:0] IMEM_ADDR,
    input  logic [nbits-1:0] IMEM_RDATA,
    input  logic             IMEM_VALID,
    output logic [nbits-1:0] IR_OUT,
    output logic [nbits-1:0] NPC_OUT,
    output logic [nbits-1:0] PC_OUT,
    output logic             IF_VALID
);

    localparam logic [nbits-1:0] NOP = nbits'(NOP_INSTR);

    fetch_state_t     state_q, state_d;
    logic             req_q, req_d;
    logic [nbits-1:0] ir_q, ir_d;
    logic [nbits-1:0] npc_q, npc_d;
    logic [nbits-1:0] pcout_q, pcout_d;
    logic             ifv_q, ifv_d;
    logic [nbits-1:0] hold_q, hold_d;

    logic             pc_inc;
    logic             pc_redirect;
    logic [nbits-1:0] pc;
    logic [nbits-1:0] pc_plus4;
    logic             issued;
    logic             accept;

    pc_gen #(
        .nbits    (nbits),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .pc_inc      (pc_inc),
        .pc_redirect (pc_redirect),
        .target      (BR_TARGET),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // IDLE re-arms the request; once it is on the bus (req_q=1) memory may
    // answer in that very cycle, so it is serviced exactly as in WAIT.
    assign issued = (state_q == WAIT) || ((state_q == IDLE) && req_q);
    assign accept = issued && IMEM_VALID;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (BR_TAKEN) begin
            // A read still in flight must be drained before the new fetch.
            state_d = ((issued || (state_q == DRAIN)) && !IMEM_VALID) ? DRAIN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && STALL) begin
                        state_d = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (accept && STALL) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (IMEM_VALID) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_d       = (state_d == IDLE) || (state_d == WAIT);
        ir_d        = ir_q;
        npc_d       = npc_q;
        pcout_d     = pcout_q;
        ifv_d       = ifv_q;
        hold_d      = hold_q;
        pc_inc      = 1'b0;
        pc_redirect = 1'b0;

        if (BR_TAKEN) begin
            pc_redirect = 1'b1;
            ir_d        = NOP;
            ifv_d       = 1'b0;
            hold_d      = NOP;
        end else if (accept && !STALL) begin
            ir_d    = IMEM_RDATA;
            pcout_d = pc;
            npc_d   = pc_plus4;
            ifv_d   = 1'b1;
            pc_inc  = 1'b1;
        end else if (accept) begin
            hold_d = IMEM_RDATA;
        end else if ((state_q == HOLD) && !STALL) begin
            ir_d    = hold_q;
            pcout_d = pc;
            npc_d   = pc_plus4;
            ifv_d   = 1'b1;
            pc_inc  = 1'b1;
        end else if (!STALL) begin
            ir_d  = NOP;
            ifv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            ir_q    <= NOP;
            npc_q   <= '0;
            pcout_q <= '0;
            ifv_q   <= 1'b0;
            hold_q  <= NOP;
        end else begin
            req_q   <= req_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            pcout_q <= pcout_d;
            ifv_q   <= ifv_d;
            hold_q  <= hold_d;
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = pc;
    assign IR_OUT    = ir_q;
    assign NPC_OUT   = npc_q;
    assign PC_OUT    = pcout_q;
    assign IF_VALID  = ifv_q;

endmodule
